// File: rtl/tic_tac_toe_auto_player.sv
// Computer tic-tac-toe opponent: scans the 8 lines over 8 cycles, then drives a move on cursor/enter.
// Define TTT_AUTO_BLOCK_EN to let the opponent-block candidate take part in the pick (normal difficulty).
module tic_tac_toe_auto_player #(
  parameter int THINK_CYCLES = 16,
  parameter bit AI_IS_X      = 1'b0,
  parameter int ACK_TIMEOUT  = 16
) (
  input  logic       CLOCK,
  input  logic       reset,
  input  logic       enable,
  input  logic [8:0] grid_state_marked,
  input  logic [8:0] grid_state_x,
  input  logic       player_x_turn,
  input  logic       someone_won,
  output logic [3:0] cell_cursor,
  output logic       cell_enter,
  output logic       busy,
  output logic [3:0] last_move,
  output logic       move_fault
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_THINK = 3'd1;
  localparam logic [2:0] S_EVAL  = 3'd2;
  localparam logic [2:0] S_PICK  = 3'd3;
  localparam logic [2:0] S_DRIVE = 3'd4;
  localparam logic [2:0] S_ENTER = 3'd5;
  localparam logic [2:0] S_ACK   = 3'd6;

  // Fallback preference, highest priority in the low nibble: center, corners, edges.
  localparam logic [35:0] PREF = {4'd7, 4'd5, 4'd3, 4'd1, 4'd8, 4'd6, 4'd2, 4'd0, 4'd4};

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  line_q, line_d;
  logic [3:0]  cursor_q, cursor_d;
  logic [3:0]  last_move_q, last_move_d;
  logic        fault_q, fault_d;
  logic        win_vld_q, win_vld_d;
  logic [3:0]  win_cell_q, win_cell_d;

  logic [8:0] own, opp, empty;
  logic       trigger, abort, accepted;
  logic [3:0] c0, c1, c2, free_cell, pick;
  logic [1:0] own_n, emp_n;
  logic       win_hit;

  assign own     = grid_state_marked & ~(grid_state_x ^ {9{AI_IS_X}});
  assign opp     = grid_state_marked &  (grid_state_x ^ {9{AI_IS_X}});
  assign empty   = ~grid_state_marked;
  assign trigger = enable & ~someone_won & (player_x_turn == AI_IS_X) & ~&grid_state_marked;
  assign abort   = ~enable | someone_won;
  assign accepted = (player_x_turn != AI_IS_X) | someone_won;

  always_comb begin
    c0 = 4'd0; c1 = 4'd0; c2 = 4'd0;
    case (line_q)
      3'd0: begin c0 = 4'd0; c1 = 4'd1; c2 = 4'd2; end
      3'd1: begin c0 = 4'd3; c1 = 4'd4; c2 = 4'd5; end
      3'd2: begin c0 = 4'd6; c1 = 4'd7; c2 = 4'd8; end
      3'd3: begin c0 = 4'd0; c1 = 4'd3; c2 = 4'd6; end
      3'd4: begin c0 = 4'd1; c1 = 4'd4; c2 = 4'd7; end
      3'd5: begin c0 = 4'd2; c1 = 4'd5; c2 = 4'd8; end
      3'd6: begin c0 = 4'd0; c1 = 4'd4; c2 = 4'd8; end
      default: begin c0 = 4'd2; c1 = 4'd4; c2 = 4'd6; end
    endcase
  end

  assign own_n     = 2'(own[c0]) + 2'(own[c1]) + 2'(own[c2]);
  assign emp_n     = 2'(empty[c0]) + 2'(empty[c1]) + 2'(empty[c2]);
  assign free_cell = empty[c0] ? c0 : (empty[c1] ? c1 : c2);
  assign win_hit   = (own_n == 2'd2) && (emp_n == 2'd1);

`ifdef TTT_AUTO_BLOCK_EN
  logic       blk_vld_q, blk_vld_d;
  logic [3:0] blk_cell_q, blk_cell_d;
  logic [1:0] opp_n;
  logic       blk_hit;

  assign opp_n   = 2'(opp[c0]) + 2'(opp[c1]) + 2'(opp[c2]);
  assign blk_hit = (opp_n == 2'd2) && (emp_n == 2'd1);

  always_comb begin
    blk_vld_d  = blk_vld_q;
    blk_cell_d = blk_cell_q;
    if (state_q == S_THINK) begin
      blk_vld_d = 1'b0;
    end else if (state_q == S_EVAL && !blk_vld_q && blk_hit) begin
      blk_vld_d  = 1'b1;
      blk_cell_d = free_cell;
    end
  end

  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      blk_vld_q  <= 1'b0;
      blk_cell_q <= 4'd0;
    end else begin
      blk_vld_q  <= blk_vld_d;
      blk_cell_q <= blk_cell_d;
    end
  end
`else
  logic unused_opp;
  assign unused_opp = ^opp;
`endif

  // Later loop iterations win, so walk the preference list from lowest priority up.
  always_comb begin
    pick = 4'd4;
    for (int i = 8; i >= 0; i--) begin
      if (empty[PREF[i*4 +: 4]]) pick = PREF[i*4 +: 4];
    end
`ifdef TTT_AUTO_BLOCK_EN
    if (blk_vld_q) pick = blk_cell_q;
`endif
    if (win_vld_q) pick = win_cell_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    line_d      = line_q;
    cursor_d    = cursor_q;
    last_move_d = last_move_q;
    fault_d     = fault_q;
    win_vld_d   = win_vld_q;
    win_cell_d  = win_cell_q;
    case (state_q)
      S_IDLE: if (trigger) begin
        state_d = S_THINK;
        cnt_d   = 16'd0;
      end
      S_THINK: begin
        win_vld_d = 1'b0;
        line_d    = 3'd0;
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == 16'(THINK_CYCLES - 1)) begin
          state_d = S_EVAL;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_EVAL: begin
        if (!win_vld_q && win_hit) begin
          win_vld_d  = 1'b1;
          win_cell_d = free_cell;
        end
        if (abort) state_d = S_IDLE;
        else if (line_q == 3'd7) state_d = S_PICK;
        else line_d = line_q + 3'd1;
      end
      S_PICK: begin
        if (~&grid_state_marked) begin
          cursor_d = pick;
          state_d  = S_DRIVE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRIVE: state_d = S_ENTER;
      S_ENTER: begin
        last_move_d = cursor_q;
        cnt_d       = 16'd0;
        state_d     = S_ACK;
      end
      S_ACK: begin
        if (accepted) begin
          state_d = S_IDLE;
        end else if (cnt_q == 16'(ACK_TIMEOUT - 1)) begin
          fault_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 16'd0;
      line_q      <= 3'd0;
      cursor_q    <= 4'd4;
      last_move_q <= 4'hF;
      fault_q     <= 1'b0;
      win_vld_q   <= 1'b0;
      win_cell_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      line_q      <= line_d;
      cursor_q    <= cursor_d;
      last_move_q <= last_move_d;
      fault_q     <= fault_d;
      win_vld_q   <= win_vld_d;
      win_cell_q  <= win_cell_d;
    end
  end

  assign cell_cursor = cursor_q;
  assign cell_enter  = (state_q == S_ENTER);
  assign busy        = (state_q != S_IDLE);
  assign last_move   = last_move_q;
  assign move_fault  = fault_q;
endmodule

// File: tb/tb_tic_tac_toe_auto_player.sv
// Randomized bench for tic_tac_toe_auto_player playing O; expected moves come from a line-scan model.
module tb_tic_tac_toe_auto_player;
  localparam int THINK = 4;
  localparam int ACKTO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [8:0] marked, xs;
  logic       x_turn, won;
  logic [3:0] cell_cursor, last_move;
  logic       cell_enter, busy, move_fault;

  int n_cmp = 0;
  int n_err = 0;
  int brd [9];   // 0 empty, 1 X, 2 O (the AI)
  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
  int pref [9] = '{4, 0, 2, 6, 8, 1, 3, 5, 7};

  always #5 clk = ~clk;

  tic_tac_toe_auto_player #(.THINK_CYCLES(THINK), .AI_IS_X(1'b0), .ACK_TIMEOUT(ACKTO)) dut (
    .CLOCK(clk), .reset(rst), .enable(enable),
    .grid_state_marked(marked), .grid_state_x(xs),
    .player_x_turn(x_turn), .someone_won(won),
    .cell_cursor(cell_cursor), .cell_enter(cell_enter), .busy(busy),
    .last_move(last_move), .move_fault(move_fault)
  );

  function automatic int model_pick();
    int win = -1, blk = -1;
    for (int l = 0; l < 8; l++) begin
      int own = 0, opp = 0, emp = 0, ec = 0;
      for (int j = 0; j < 3; j++) begin
        int c = lines[l][j];
        if (brd[c] == 2) own++;
        else if (brd[c] == 1) opp++;
        else begin emp++; ec = c; end
      end
      if (win < 0 && own == 2 && emp == 1) win = ec;
      if (blk < 0 && opp == 2 && emp == 1) blk = ec;
    end
    if (win >= 0) return win;
`ifdef TTT_AUTO_BLOCK_EN
    if (blk >= 0) return blk;
`endif
    foreach (pref[i]) if (brd[pref[i]] == 0) return pref[i];
    return -1;
  endfunction

  task automatic load_board();
    for (int i = 0; i < 9; i++) begin
      marked[i] = (brd[i] != 0);
      xs[i]     = (brd[i] == 1);
    end
  endtask

  // Launch a move on the current board; accept=0 leaves the turn unflipped so the ack times out.
  task automatic do_move(input string name, input bit accept);
    int exp_c, k_en, npulse;
    logic [3:0] prev_cur;
    exp_c = model_pick();
    @(negedge clk);
    load_board();
    x_turn = 1'b0; won = 1'b0; enable = 1'b1;
    k_en = -1; npulse = 0; prev_cur = cell_cursor;
    for (int k = 1; k <= THINK + 11 + ACKTO + 3; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL %s busy_rise: got %b want 1", name, busy); end
      end
      if (cell_enter === 1'b1) begin
        npulse++;
        if (k_en < 0) begin
          k_en = k;
          n_cmp++;
          if (cell_cursor !== 4'(exp_c) || prev_cur !== 4'(exp_c)) begin
            n_err++;
            $display("FAIL %s cursor: got %0d (prev %0d) want %0d", name, cell_cursor, prev_cur, exp_c);
          end
          if (accept) x_turn = 1'b1;
        end
      end
      if (k_en > 0 && k == k_en + 1 && !accept) enable = 1'b0;
      if (k_en > 0 && accept && k == k_en + 1) begin
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL %s busy_in_ack: got %b want 1", name, busy); end
      end
      if (k_en > 0 && accept && k == k_en + 2) begin
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL %s busy_fall: got %b want 0", name, busy); end
      end
      if (k_en > 0 && !accept && k == k_en + ACKTO - 1) begin
        n_cmp++;
        if (move_fault !== 1'b0) begin n_err++; $display("FAIL %s fault_early: got %b want 0", name, move_fault); end
      end
      if (k_en > 0 && !accept && k == k_en + ACKTO + 1) begin
        n_cmp++;
        if (move_fault !== 1'b1 || busy !== 1'b0) begin
          n_err++;
          $display("FAIL %s timeout: fault %b busy %b want fault 1 busy 0", name, move_fault, busy);
        end
      end
      prev_cur = cell_cursor;
    end
    n_cmp++;
    if (k_en != THINK + 11 || npulse != 1) begin
      n_err++;
      $display("FAIL %s enter_timing: at t+%0d pulses %0d want t+%0d pulses 1", name, k_en, npulse, THINK + 11);
    end
    n_cmp++;
    if (last_move !== 4'(exp_c)) begin n_err++; $display("FAIL %s last_move: got %0d want %0d", name, last_move, exp_c); end
    enable = 1'b0; x_turn = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    n_cmp++;
    if (cell_cursor !== 4'd4 || cell_enter !== 1'b0 || busy !== 1'b0 || last_move !== 4'hF || move_fault !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: cur %0d en %b busy %b last %h fault %b want 4 0 0 f 0", cell_cursor, cell_enter, busy, last_move, move_fault);
    end
    rst = 1'b0;
    foreach (brd[i]) brd[i] = 0;
    brd[4] = 1;
    @(negedge clk); load_board(); enable = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL reset_pre_busy: got %b want 1", busy); end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (cell_cursor !== 4'd4 || cell_enter !== 1'b0 || busy !== 1'b0 || last_move !== 4'hF || move_fault !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_think: cur %0d en %b busy %b last %h fault %b want 4 0 0 f 0", cell_cursor, cell_enter, busy, last_move, move_fault);
    end
    enable = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_empty_board();
    foreach (brd[i]) brd[i] = 0;
    do_move("empty_board", 1'b1);
  endtask

  task automatic test_win_over_block();
    foreach (brd[i]) brd[i] = 0;
    brd[0] = 2; brd[1] = 2; brd[3] = 1; brd[4] = 1;
    n_cmp++;
    if (model_pick() != 2) begin n_err++; $display("FAIL win_model: got %0d want 2", model_pick()); end
    do_move("win_over_block", 1'b1);
  endtask

  task automatic test_block();
    int want;
`ifdef TTT_AUTO_BLOCK_EN
    want = 5;
`else
    want = 2;
`endif
    foreach (brd[i]) brd[i] = 0;
    brd[0] = 2; brd[3] = 1; brd[4] = 1;
    n_cmp++;
    if (model_pick() != want) begin n_err++; $display("FAIL block_model: got %0d want %0d", model_pick(), want); end
    do_move("block", 1'b1);
  endtask

  task automatic test_abort();
    logic [3:0] lm;
    int npulse = 0;
    foreach (brd[i]) brd[i] = 0;
    brd[0] = 1;
    lm = last_move;
    @(negedge clk); load_board(); won = 1'b0; enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL abort_think: busy %b want 1", busy); end
    won = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL abort_idle: busy %b want 0", busy); end
    for (int k = 0; k < THINK + 16; k++) begin
      @(negedge clk);
      if (cell_enter === 1'b1) npulse++;
    end
    n_cmp++;
    if (npulse != 0 || last_move !== lm) begin
      n_err++;
      $display("FAIL abort_no_enter: pulses %0d last %0d want 0 pulses last %0d", npulse, last_move, lm);
    end
    won = 1'b0; enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      foreach (brd[i]) brd[i] = int'($urandom_range(0, 2));
      brd[$urandom_range(0, 8)] = 0;
      do_move("random", 1'b1);
    end
  endtask

  task automatic test_timeout();
    foreach (brd[i]) brd[i] = 0;
    brd[2] = 1; brd[4] = 2;
    do_move("timeout", 1'b0);
    foreach (brd[i]) brd[i] = 0;
    brd[8] = 1;
    do_move("after_fault", 1'b1);
    n_cmp++;
    if (move_fault !== 1'b1) begin n_err++; $display("FAIL fault_sticky: got %b want 1", move_fault); end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (move_fault !== 1'b0) begin n_err++; $display("FAIL fault_clear: got %b want 0", move_fault); end
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; marked = '0; xs = '0; x_turn = 1'b0; won = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_empty_board();
    test_win_over_block();
    test_block();
    test_abort();
    test_random();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
